// File: rtl/mw_pipe_reg.sv
// mw_pipe_reg: parametrised MEM/WB pipeline register with valid, stall, flush
// and a registered occupancy count; outputs come straight from the last stage.
module mw_pipe_reg #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       INSN_W = 32,
  parameter int unsigned       DEPTH  = 1,
  parameter logic [INSN_W-1:0] NOP    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] o_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              ovf_in,
  input  logic [INSN_W-1:0] ins_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] d_out,
  output logic              ovf_out,
  output logic [INSN_W-1:0] ins_out,
  output logic [2:0]        occupancy
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mw_pipe_reg: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] o;
    logic [DATA_W-1:0] d;
    logic              ovf;
    logic [INSN_W-1:0] ins;
  } stage_t;

  function automatic stage_t empty_stage();
    stage_t s;
    s.valid = 1'b0;
    s.o     = '0;
    s.d     = '0;
    s.ovf   = 1'b0;
    s.ins   = NOP;
    return s;
  endfunction

  stage_t     stage_q [DEPTH];
  stage_t     stage_d [DEPTH];
  stage_t     in_entry_s;
  logic [2:0] occupancy_q;
  logic [2:0] occupancy_d;

  // Bubbles keep o/d from the bus but must decode as inert in writeback.
  always_comb begin
    in_entry_s.valid = valid_in;
    in_entry_s.o     = o_in;
    in_entry_s.d     = d_in;
    if (valid_in) begin
      in_entry_s.ovf = ovf_in;
      in_entry_s.ins = ins_in;
    end else begin
      in_entry_s.ovf = 1'b0;
      in_entry_s.ins = NOP;
    end
  end

  // Next-state: flush clears, stall holds, otherwise shift by one stage.
  always_comb begin
    stage_d     = stage_q;
    occupancy_d = occupancy_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = empty_stage();
      end
      occupancy_d = 3'd0;
    end else if (stall) begin
      stage_d     = stage_q;
      occupancy_d = occupancy_q;
    end else begin
      stage_d[0] = in_entry_s;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      occupancy_d = occupancy_q + {2'b00, valid_in} - {2'b00, stage_q[DEPTH-1].valid};
    end
  end

  // Stage and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= empty_stage();
      end
      occupancy_q <= 3'd0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      occupancy_q <= occupancy_d;
    end
  end

  assign valid_out = stage_q[DEPTH-1].valid;
  assign o_out     = stage_q[DEPTH-1].o;
  assign d_out     = stage_q[DEPTH-1].d;
  assign ovf_out   = stage_q[DEPTH-1].ovf;
  assign ins_out   = stage_q[DEPTH-1].ins;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Bench for mw_pipe_reg: five instances (DEPTH 1..4 narrow, DEPTH 2 wide with
// NOP=0x13) share one stimulus stream and are compared to a queue-based model.
module tb_mw_pipe_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, valid_in, ovf_in;
  logic [63:0] o_in, d_in;
  logic [31:0] ins_in;

  logic        dut_v   [5];
  logic [63:0] dut_o   [5];
  logic [63:0] dut_d   [5];
  logic        dut_ovf [5];
  logic [31:0] dut_ins [5];
  logic [2:0]  dut_occ [5];

  for (genvar g = 0; g < 4; g++) begin : g_narrow
    logic [31:0] oo, dd, ii;
    logic        vv, ff;
    logic [2:0]  cc;
    mw_pipe_reg #(.DATA_W(32), .INSN_W(32), .DEPTH(g + 1), .NOP(32'h0)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .o_in(o_in[31:0]), .d_in(d_in[31:0]),
      .ovf_in(ovf_in), .ins_in(ins_in),
      .valid_out(vv), .o_out(oo), .d_out(dd), .ovf_out(ff), .ins_out(ii),
      .occupancy(cc)
    );
    assign dut_v[g]   = vv;
    assign dut_o[g]   = {32'h0, oo};
    assign dut_d[g]   = {32'h0, dd};
    assign dut_ovf[g] = ff;
    assign dut_ins[g] = ii;
    assign dut_occ[g] = cc;
  end

  mw_pipe_reg #(.DATA_W(64), .INSN_W(32), .DEPTH(2), .NOP(32'h13)) u_wide (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .o_in(o_in), .d_in(d_in),
    .ovf_in(ovf_in), .ins_in(ins_in),
    .valid_out(dut_v[4]), .o_out(dut_o[4]), .d_out(dut_d[4]),
    .ovf_out(dut_ovf[4]), .ins_out(dut_ins[4]), .occupancy(dut_occ[4])
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [63:0] o;
    logic [63:0] d;
    logic        ovf;
    logic [31:0] ins;
  } entry_t;

  entry_t      mq [5][$];
  int          depth_of [5] = '{1, 2, 3, 4, 2};
  logic [31:0] nop_of   [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h13};
  int          checks = 0;
  int          errors = 0;

  function automatic entry_t blank(int i);
    entry_t e;
    e.v = 1'b0; e.o = 64'h0; e.d = 64'h0; e.ovf = 1'b0; e.ins = nop_of[i];
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      mq[i].delete();
      for (int k = 0; k < depth_of[i]; k++) mq[i].push_back(blank(i));
    end
  endtask

  // Applies one clock edge to the model using the inputs presented at that edge.
  task automatic model_edge();
    entry_t e;
    if (reset || flush) begin
      model_clear();
    end else if (!stall) begin
      for (int i = 0; i < 5; i++) begin
        e.v   = valid_in;
        e.o   = (i == 4) ? o_in : {32'h0, o_in[31:0]};
        e.d   = (i == 4) ? d_in : {32'h0, d_in[31:0]};
        e.ovf = valid_in ? ovf_in : 1'b0;
        e.ins = valid_in ? ins_in : nop_of[i];
        mq[i].push_front(e);
        void'(mq[i].pop_back());
      end
    end
  endtask

  function automatic int model_occ(int i);
    int n = 0;
    foreach (mq[i][k]) if (mq[i][k].v) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; ovf_in = 1'b0;
    o_in = 64'h0; d_in = 64'h0; ins_in = 32'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; valid_in = 1'b1; o_in = 64'hDEADBEEF; d_in = 64'h5555; ovf_in = 1'b1; ins_in = 32'h99;
    step();
    reset = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_v[i] !== 1'b0 || dut_o[i] !== 64'h0 || dut_d[i] !== 64'h0 || dut_ovf[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got v=%0b o=%h d=%h ovf=%0b, want all zero", i, dut_v[i], dut_o[i], dut_d[i], dut_ovf[i]);
      end
      checks++;
      if (dut_ins[i] !== nop_of[i] || dut_occ[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset_ins_occ[%0d]: got ins=%h occ=%0d, want ins=%h occ=0", i, dut_ins[i], dut_occ[i], nop_of[i]);
      end
    end
  endtask

  task automatic test_fill_drain();
    int   exp_occ [8] = '{1, 2, 3, 3, 2, 1, 0, 0};
    logic exp_v   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      valid_in = (t < 4);
      o_in     = 64'(t + 1);
      ins_in   = 32'(t + 1);
      step();
      checks++;
      if (dut_occ[2] !== 3'(exp_occ[t]) || dut_v[2] !== exp_v[t]) begin
        errors++;
        $display("FAIL fill_drain_occ t=%0d: got occ=%0d v=%0b, want occ=%0d v=%0b", t, dut_occ[2], dut_v[2], exp_occ[t], exp_v[t]);
      end
      if (exp_v[t]) begin
        checks++;
        if (dut_o[2] !== 64'(t - 1)) begin
          errors++;
          $display("FAIL fill_drain_o t=%0d: got %0d want %0d", t, dut_o[2], t - 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    valid_in = 1'b1; o_in = 64'hA0A0; ins_in = 32'hA; step();
    o_in = 64'hB0B0; ins_in = 32'hB; step();
    stall = 1'b1;
    for (int t = 0; t < 3; t++) begin
      o_in = {32'h0, $urandom}; ins_in = $urandom; valid_in = 1'b1;
      step();
      checks++;
      if (dut_o[1] !== 64'hA0A0 || dut_v[1] !== 1'b1 || dut_occ[1] !== 3'd2) begin
        errors++;
        $display("FAIL stall_hold t=%0d: got o=%h v=%0b occ=%0d, want o=a0a0 v=1 occ=2", t, dut_o[1], dut_v[1], dut_occ[1]);
      end
    end
    stall = 1'b0; valid_in = 1'b1; o_in = 64'hC0C0; ins_in = 32'hC; step();
    checks++;
    if (dut_o[1] !== 64'hB0B0 || dut_ins[1] !== 32'hB || dut_occ[1] !== 3'd2) begin
      errors++;
      $display("FAIL stall_release_b: got o=%h ins=%h occ=%0d, want o=b0b0 ins=b occ=2", dut_o[1], dut_ins[1], dut_occ[1]);
    end
    valid_in = 1'b0; step();
    checks++;
    if (dut_o[1] !== 64'hC0C0 || dut_v[1] !== 1'b1 || dut_occ[1] !== 3'd1) begin
      errors++;
      $display("FAIL stall_release_c: got o=%h v=%0b occ=%0d, want o=c0c0 v=1 occ=1", dut_o[1], dut_v[1], dut_occ[1]);
    end
  endtask

  task automatic test_flush_stall();
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      valid_in = 1'b1; o_in = 64'(16 + t); ins_in = 32'(16 + t); step();
    end
    checks++;
    if (dut_occ[3] !== 3'd4 || dut_o[3] !== 64'd16) begin
      errors++;
      $display("FAIL flush_fill: got occ=%0d o=%0d, want occ=4 o=16", dut_occ[3], dut_o[3]);
    end
    stall = 1'b1; flush = 1'b1; valid_in = 1'b1; o_in = 64'hBAD; ins_in = 32'h77; step();
    stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    checks++;
    if (dut_v[3] !== 1'b0 || dut_ins[3] !== 32'h0 || dut_occ[3] !== 3'd0) begin
      errors++;
      $display("FAIL flush_over_stall: got v=%0b ins=%h occ=%0d, want v=0 ins=0 occ=0", dut_v[3], dut_ins[3], dut_occ[3]);
    end
    for (int t = 0; t < 4; t++) begin
      step();
      checks++;
      if (dut_v[3] !== 1'b0 || dut_ins[3] === 32'h77) begin
        errors++;
        $display("FAIL flush_discard t=%0d: got v=%0b ins=%h, want v=0 ins=0", t, dut_v[3], dut_ins[3]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic        pat_v   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] pat_ins [3] = '{32'h11, 32'h22, 32'h33};
    logic [31:0] exp_ins [3] = '{32'h11, 32'h0, 32'h33};
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    ovf_in = 1'b1;
    for (int t = 0; t < 3; t++) begin
      valid_in = pat_v[t]; ins_in = pat_ins[t]; step();
      checks++;
      if (dut_v[0] !== pat_v[t] || dut_ins[0] !== exp_ins[t] || dut_ovf[0] !== pat_v[t]) begin
        errors++;
        $display("FAIL bubble t=%0d: got v=%0b ins=%h ovf=%0b, want v=%0b ins=%h ovf=%0b",
                 t, dut_v[0], dut_ins[0], dut_ovf[0], pat_v[t], exp_ins[t], pat_v[t]);
      end
    end
  endtask

  task automatic test_wide();
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    valid_in = 1'b1; o_in = 64'hFFFF_0000_1234_5678; d_in = 64'h0123_4567_89AB_CDEF; ins_in = 32'h55; step();
    valid_in = 1'b0; step();
    checks++;
    if (dut_o[4] !== 64'hFFFF_0000_1234_5678 || dut_d[4] !== 64'h0123_4567_89AB_CDEF || dut_ins[4] !== 32'h55) begin
      errors++;
      $display("FAIL wide_pass: got o=%h d=%h ins=%h", dut_o[4], dut_d[4], dut_ins[4]);
    end
    flush = 1'b1; step(); flush = 1'b0;
    checks++;
    if (dut_ins[4] !== 32'h13 || dut_v[4] !== 1'b0 || dut_o[4] !== 64'h0) begin
      errors++;
      $display("FAIL wide_flush: got ins=%h v=%0b o=%h, want ins=13 v=0 o=0", dut_ins[4], dut_v[4], dut_o[4]);
    end
  endtask

  task automatic test_random();
    entry_t e;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(99) < 2);
      flush    = ($urandom_range(99) < 4);
      stall    = ($urandom_range(99) < 25);
      valid_in = ($urandom_range(99) < 70);
      ovf_in   = $urandom_range(1);
      o_in     = {$urandom, $urandom};
      d_in     = {$urandom, $urandom};
      ins_in   = $urandom;
      step();
      for (int i = 0; i < 5; i++) begin
        e = mq[i][$];
        checks++;
        if (dut_v[i] !== e.v || dut_ovf[i] !== e.ovf || dut_ins[i] !== e.ins) begin
          errors++;
          $display("FAIL rand_ctrl[%0d] c=%0d: got v=%0b ovf=%0b ins=%h, want v=%0b ovf=%0b ins=%h",
                   i, c, dut_v[i], dut_ovf[i], dut_ins[i], e.v, e.ovf, e.ins);
        end
        checks++;
        if (dut_o[i] !== e.o || dut_d[i] !== e.d) begin
          errors++;
          $display("FAIL rand_data[%0d] c=%0d: got o=%h d=%h, want o=%h d=%h", i, c, dut_o[i], dut_d[i], e.o, e.d);
        end
        checks++;
        if (dut_occ[i] !== 3'(model_occ(i))) begin
          errors++;
          $display("FAIL rand_occ[%0d] c=%0d: got %0d want %0d", i, c, dut_occ[i], model_occ(i));
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_stall();
    test_flush_stall();
    test_bubbles();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
